spi3w_resp_regs: RTL and testbench

- 3-wire SPI responder (slave) with local register bank; opposite end of the team's 3-wire SPI initiator (sclk, cs, shared sdio).
- Oversamples sclk/cs/sdio in the system clock domain, decodes command/address/data frames, services writes into the bank and drives read data back on sdio.
- Exposes a one-cycle write strobe to local logic.
- Sits beside the initiator in the SPI top level.

---
 rtl/spi3w_resp_regs.sv | 199 +++++++++++++++++++
 tb/tb_spi3w_resp_regs.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi3w_resp_regs.sv
// Purpose : 3-wire SPI responder with a DEPTH-entry local register bank (R/W bit, address, data; MSB first).
// Latency : 3 clk from an sclk/cs pin edge to the resulting action (2-flop sync + edge detect); wr_stb 3 clk after last data rise.
// Backpressure: none; the responder follows the initiator's sclk and must run at >= 8x the sclk rate.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   sclk, cs, sdio  SPI pins (sclk idles low, cs active low, sdio shared and driven only while sdio_oe=1)
//   sdio_oe         responder output enable, forced low whenever synchronized cs is high
//   wr_stb/addr/data  one-cycle commit strobe and the address/data of the last committed write
//   frame_err       one-cycle pulse when a frame is aborted
//   busy            frame in progress (not IDLE, not DONE)
// Optional: define SPI_RESP_TIMEOUT_EN to abort a frame after TIMEOUT clk cycles without an sclk edge.
module spi3w_resp_regs #(
    parameter int a_width = 16,
    parameter int d_width = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               cs,
    inout  wire                sdio,
    output logic               sdio_oe,
    output logic               wr_stb,
    output logic [a_width-1:0] wr_addr,
    output logic [d_width-1:0] wr_data,
    output logic               frame_err,
    output logic               busy
);

    localparam int MAXW = (a_width > d_width) ? a_width : d_width;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int IW   = $clog2(DEPTH);
    localparam logic [CW-1:0]  A_LAST  = CW'(a_width - 1);
    localparam logic [CW-1:0]  D_LAST  = CW'(d_width - 1);
    localparam logic [CW-1:0]  D_ALL   = CW'(d_width);
    localparam logic [a_width:0] DEPTH_L = (a_width + 1)'(DEPTH);

    if (a_width < 2 || d_width < 2 || DEPTH < 2 || TIMEOUT < 1 || a_width < IW) begin : g_param_check
        $error("spi3w_resp_regs: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_DONE
    } state_t;

    state_t state, state_n;

    logic sclk_s1, sclk_s2, sclk_d;
    logic cs_s1, cs_s2, cs_d;
    logic sdio_s1, sdio_s2;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CW-1:0]      bit_cnt;
    logic               rw;
    logic [a_width-1:0] addr_sr, addr_nx;
    logic [d_width-1:0] data_sr, data_nx;
    logic [d_width-1:0] rd_sr;
    logic [d_width-1:0] regs [DEPTH];
    logic               oe_q, sdio_out;
    logic               commit, abort, tmo;

    function automatic logic in_range(input logic [a_width-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Synchronizers; cs resets high so reset release with cs idle is not seen as a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_d   <= 1'b1;
            sdio_s1 <= 1'b0; sdio_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;  sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            cs_s1   <= cs;    cs_s2   <= cs_s1;   cs_d   <= cs_s2;
            sdio_s1 <= sdio;  sdio_s2 <= sdio_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign cs_fall   = ~cs_s2 & cs_d;

    // sdio_s2 is aligned with sclk_s2, so it is the bit present at the pin's sclk rise.
    assign addr_nx = {addr_sr[a_width-2:0], sdio_s2};
    assign data_nx = {data_sr[d_width-2:0], sdio_s2};

    assign busy = (state != S_IDLE) && (state != S_DONE);

`ifdef SPI_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (!busy || sclk_rise || sclk_fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th consecutive idle cycle of an open frame.
    assign tmo = busy && !sclk_rise && !sclk_fall && (tmo_cnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state)
            S_IDLE:  if (cs_fall) state_n = S_CMD;
            S_CMD:   if (sclk_rise) state_n = S_ADDR;
            S_ADDR:  if (sclk_rise && bit_cnt == A_LAST) state_n = rw ? S_TURN : S_WDATA;
            S_WDATA: if (sclk_rise && bit_cnt == D_LAST) begin
                         state_n = S_DONE;
                         commit  = in_range(addr_sr);
                     end
            S_TURN:  if (sclk_fall) state_n = S_RDATA;
            S_RDATA: if (sclk_fall && bit_cnt == D_ALL) state_n = S_DONE;
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (tmo) begin
            state_n = S_DONE;
            abort   = 1'b1;
            commit  = 1'b0;
        end
        // cs rise has priority over a coincident sclk edge: an unfinished frame never commits.
        if (cs_rise) begin
            if (state != S_IDLE && state != S_DONE) abort = 1'b1;
            state_n = S_IDLE;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            addr_sr   <= '0;
            data_sr   <= '0;
            rd_sr     <= '0;
            oe_q      <= 1'b0;
            sdio_out  <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state     <= state_n;
            wr_stb    <= commit;
            frame_err <= abort;

            if (state_n != state) begin
                bit_cnt <= '0;
            end else if (sclk_rise && (state == S_ADDR || state == S_WDATA || state == S_RDATA)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == S_CMD && sclk_rise)   rw      <= sdio_s2;
            if (state == S_ADDR && sclk_rise)  addr_sr <= addr_nx;
            if (state == S_WDATA && sclk_rise) data_sr <= data_nx;

            if (commit) begin
                regs[addr_sr[IW-1:0]] <= data_nx;
                wr_addr               <= addr_sr;
                wr_data               <= data_nx;
            end

            // Read data is snapshotted as the address completes; out-of-range reads return zero.
            if (state == S_ADDR && state_n == S_TURN) begin
                rd_sr <= in_range(addr_nx) ? regs[addr_nx[IW-1:0]] : '0;
            end else if ((state == S_TURN || state == S_RDATA) && state_n == S_RDATA && sclk_fall) begin
                rd_sr <= rd_sr << 1;
            end

            if ((state == S_TURN || state == S_RDATA) && state_n == S_RDATA && sclk_fall) begin
                oe_q     <= 1'b1;
                sdio_out <= rd_sr[d_width-1];
            end else if (state_n != S_RDATA) begin
                oe_q     <= 1'b0;
                sdio_out <= 1'b0;
            end
        end
    end

    assign sdio_oe = oe_q & ~cs_s2;
    assign sdio    = sdio_oe ? sdio_out : 1'bz;

endmodule

// File: tb/tb_spi3w_resp_regs.sv
module tb_spi3w_resp_regs;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 1024;
    localparam int HALF    = 8;
    localparam int TOTAL   = 1 + AW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          cs;
    logic          tb_oe;
    logic          tb_drv;
    wire           sdio;
    logic          sdio_oe;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_err;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;
    int clash_cnt = 0;

    logic [DW-1:0] ref_regs [DEPTH];
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;

    assign sdio = tb_oe ? tb_drv : 1'bz;

    always #5 clk = ~clk;

    spi3w_resp_regs #(.a_width(AW), .d_width(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .sdio(sdio), .sdio_oe(sdio_oe),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk) begin
        if (wr_stb)            stb_cnt++;
        if (frame_err)         err_cnt++;
        if (sdio_oe)           oe_cnt++;
        if (sdio_oe && tb_oe)  clash_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tb_oe = 1'b1; tb_drv = b;
        tick(HALF); sclk = 1'b1;
        tick(HALF); sclk = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tb_oe = 1'b0;
        tick(HALF);
        chk("rd_oe", 32'(sdio_oe), 1);
        b = sdio;
        sclk = 1'b1;
        tick(HALF); sclk = 1'b0;
    endtask

    // One initiator frame; stops after nbits clocked bits, optionally raising cs together with the last rise.
    task automatic spi_xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input int nbits, input bit cs_last, output logic [DW-1:0] rd);
        logic [TOTAL-1:0] frame;
        logic b;
        frame = {rw, addr, wd};
        rd = '0;
        cs = 1'b0;
        tick(4);
        chk("busy_frame", 32'(busy), 1);
        for (int i = 0; i < nbits && i < TOTAL; i++) begin
            if (rw && i > AW) begin
                read_bit(b);
                rd = {rd[DW-2:0], b};
            end else if (cs_last && i == nbits - 1) begin
                tb_oe = 1'b1; tb_drv = frame[TOTAL-1-i];
                tick(HALF); sclk = 1'b1; cs = 1'b1;
                tick(HALF); sclk = 1'b0;
            end else begin
                send_bit(frame[TOTAL-1-i]);
            end
            if (rw && i == AW) tb_oe = 1'b0;
        end
        tick(4);
        if (nbits >= TOTAL && !cs_last) begin
            chk("busy_done", 32'(busy), 0);
            if (rw) chk("rd_release", 32'(sdio_oe), 0);
        end
        cs = 1'b1; tb_oe = 1'b0;
        tick(6);
        chk("oe_after_cs", 32'(sdio_oe), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic do_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input int nbits, input bit cs_last);
        int stb0, err0, oe0;
        bit complete, inrange;
        logic [DW-1:0] rd;
        complete = (nbits >= TOTAL) && !cs_last;
        inrange  = (int'(addr) < DEPTH);
        stb0 = stb_cnt; err0 = err_cnt; oe0 = oe_cnt;
        spi_xfer(rw, addr, wd, nbits, cs_last, rd);
        chk("frame_err", err_cnt - err0, complete ? 0 : 1);
        if (!rw) begin
            chk("wr_stb", stb_cnt - stb0, (complete && inrange) ? 1 : 0);
            chk("wr_no_drive", oe_cnt - oe0, 0);
            if (complete && inrange) begin
                ref_regs[int'(addr)] = wd;
                exp_wa = addr;
                exp_wd = wd;
            end
            chk("wr_addr", 32'(wr_addr), 32'(exp_wa));
            chk("wr_data", 32'(wr_data), 32'(exp_wd));
        end else begin
            chk("rd_no_stb", stb_cnt - stb0, 0);
            if (complete) chk("rd_data", 32'(rd), inrange ? 32'(ref_regs[int'(addr)]) : 0);
        end
    endtask

    initial begin : main
        logic          r_rw;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_d;
        int            r_nb;
        int            err0, stb0;
        logic [TOTAL-1:0] fr;
        logic          b;
        logic [DW-1:0] rd;

        rst = 1'b0; cs = 1'b1; sclk = 1'b0; tb_oe = 1'b0; tb_drv = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;
        exp_wa = '0; exp_wd = '0;
        tick(5);
        chk("rst_oe", 32'(sdio_oe), 0);
        chk("rst_stb", 32'(wr_stb), 0);
        chk("rst_waddr", 32'(wr_addr), 0);
        chk("rst_wdata", 32'(wr_data), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        tick(5);

        do_frame(1'b0, 16'h0003, 8'hA5, TOTAL, 1'b0);
        do_frame(1'b1, 16'h0003, 8'h00, TOTAL, 1'b0);
        do_frame(1'b0, 16'h0040, 8'h3C, TOTAL, 1'b0);
        do_frame(1'b1, 16'h0040, 8'h00, TOTAL, 1'b0);
        do_frame(1'b1, 16'h0003, 8'h00, TOTAL, 1'b0);
        do_frame(1'b0, 16'h0001, 8'hFF, 1 + AW + 5, 1'b0);
        do_frame(1'b1, 16'h0001, 8'h00, TOTAL, 1'b0);
        do_frame(1'b0, 16'h0002, 8'h5A, TOTAL, 1'b1);
        do_frame(1'b1, 16'h0002, 8'h00, TOTAL, 1'b0);
        do_frame(1'b0, AW'(DEPTH - 1), 8'h77, TOTAL, 1'b0);
        do_frame(1'b0, AW'(DEPTH), 8'h11, TOTAL, 1'b0);
        do_frame(1'b1, AW'(DEPTH - 1), 8'h00, TOTAL, 1'b0);
        do_frame(1'b1, AW'(DEPTH), 8'h00, TOTAL, 1'b0);
        do_frame(1'b1, 16'h0004, 8'h00, 1 + AW, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r_rw = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
            r_d  = DW'($urandom);
            r_nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TOTAL - 1)) : TOTAL;
            do_frame(r_rw, r_a, r_d, r_nb, 1'b0);
        end

        // sclk stalls mid-address with cs held low
        fr = {1'b0, 16'h0005, 8'h96};
        err0 = err_cnt; stb0 = stb_cnt;
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) send_bit(fr[TOTAL-1-i]);
        tick(TIMEOUT + 5);
`ifdef SPI_RESP_TIMEOUT_EN
        chk("tmo_ferr", err_cnt - err0, 1);
        chk("tmo_busy", 32'(busy), 0);
        chk("tmo_oe", 32'(sdio_oe), 0);
        cs = 1'b1; tb_oe = 1'b0;
        tick(6);
        chk("tmo_no_2nd_err", err_cnt - err0, 1);
        chk("tmo_no_stb", stb_cnt - stb0, 0);
`else
        chk("stall_busy", 32'(busy), 1);
        chk("stall_no_err", err_cnt - err0, 0);
        for (int i = 5; i < TOTAL; i++) send_bit(fr[TOTAL-1-i]);
        tick(4);
        cs = 1'b1; tb_oe = 1'b0;
        tick(6);
        ref_regs[5] = 8'h96; exp_wa = 16'h0005; exp_wd = 8'h96;
        chk("stall_stb", stb_cnt - stb0, 1);
        chk("stall_wdata", 32'(wr_data), 32'h96);
`endif
        do_frame(1'b1, 16'h0005, 8'h00, TOTAL, 1'b0);

        // reset asserted while the responder is driving read data bit 4
        do_frame(1'b0, 16'h0003, 8'hC3, TOTAL, 1'b0);
        fr = {1'b1, 16'h0003, 8'h00};
        cs = 1'b0;
        tick(4);
        for (int i = 0; i <= AW; i++) send_bit(fr[TOTAL-1-i]);
        tb_oe = 1'b0;
        for (int i = 0; i < 3; i++) read_bit(b);
        tick(4);
        chk("pre_rst_oe", 32'(sdio_oe), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_oe", 32'(sdio_oe), 0);
        chk("mid_rst_waddr", 32'(wr_addr), 0);
        chk("mid_rst_wdata", 32'(wr_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_stb", 32'(wr_stb), 0);
        chk("mid_rst_ferr", 32'(frame_err), 0);
        cs = 1'b1; sclk = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(5);
        for (int i = 0; i < DEPTH; i++) ref_regs[i] = '0;
        exp_wa = '0; exp_wd = '0;
        do_frame(1'b1, 16'h0003, 8'h00, TOTAL, 1'b0);
        do_frame(1'b1, 16'h0005, 8'h00, TOTAL, 1'b0);
        do_frame(1'b1, AW'(DEPTH - 1), 8'h00, TOTAL, 1'b0);

        chk("sdio_contention", clash_cnt, 0);
        rd = '0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
